// File: rtl/cpu_isa_pkg.sv
// -----------------------------------------------------------------------------
// cpu_isa_pkg
//   Instruction-set constants shared by the fetch unit and the datapath decode.
//   Contents:
//     - bit positions of every decoded instruction field (COND_MSB..IVMOV_LSB)
//     - HALT_WORD, the encoding that stops instruction fetch
//     - FETCH_CNT_W, width of the RAM-latency wait counter (latency 1..7)
//     - fetch_state_t, the fetch sequencer state encoding
// -----------------------------------------------------------------------------
package cpu_isa_pkg;

  // Field layout of a 32-bit instruction word.
  localparam int COND_MSB  = 31;
  localparam int COND_LSB  = 28;
  localparam int OP_MSB    = 27;
  localparam int OP_LSB    = 24;
  localparam int S_BIT     = 23;
  localparam int DEST_MSB  = 22;
  localparam int DEST_LSB  = 19;
  localparam int SRC2_MSB  = 18;
  localparam int SRC2_LSB  = 15;
  localparam int SRC1_MSB  = 14;
  localparam int SRC1_LSB  = 11;
  localparam int SHROR_MSB = 10;
  localparam int SHROR_LSB = 6;
  // The move immediate overlaps source_2/source_1/shift fields on purpose.
  localparam int IVMOV_MSB = 18;
  localparam int IVMOV_LSB = 3;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  // Holds MEM_LATENCY-1 for latencies up to 7.
  localparam int FETCH_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/instr_field_decoder.sv
// -----------------------------------------------------------------------------
// instr_field_decoder
//   Purely combinational slicer of an instruction word into its fields.
//   Reused by the datapath decode, so it carries no state.
//   Ports:
//     instr        in   DATA_W  instruction word
//     cond         out  4       condition code
//     op_code      out  4       operation
//     s_bit        out  1       set-flags bit
//     destination  out  4       destination register
//     source_2     out  4       second source register
//     source_1     out  4       first source register
//     iv_shift_ror out  5       shift/rotate amount
//     iv_mov       out  16      move immediate
// -----------------------------------------------------------------------------
module instr_field_decoder
  import cpu_isa_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] instr,
  output logic [3:0]        cond,
  output logic [3:0]        op_code,
  output logic              s_bit,
  output logic [3:0]        destination,
  output logic [3:0]        source_2,
  output logic [3:0]        source_1,
  output logic [4:0]        iv_shift_ror,
  output logic [15:0]       iv_mov
);

  // NOTE: continuous assigns of plain slices cannot infer latches; any
  // always_comb added here must give every output a default first.
  assign cond         = instr[COND_MSB:COND_LSB];
  assign op_code      = instr[OP_MSB:OP_LSB];
  assign s_bit        = instr[S_BIT];
  assign destination  = instr[DEST_MSB:DEST_LSB];
  assign source_2     = instr[SRC2_MSB:SRC2_LSB];
  assign source_1     = instr[SRC1_MSB:SRC1_LSB];
  assign iv_shift_ror = instr[SHROR_MSB:SHROR_LSB];
  assign iv_mov       = instr[IVMOV_MSB:IVMOV_LSB];

  // The lowest bits belong to no field.
  logic unused_low_bits;
  assign unused_low_bits = ^instr[IVMOV_LSB-1:0];

endmodule

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//   Fetch stage in front of the CPU datapath. Sequences instruction-RAM reads,
//   holds the program counter, registers each fetched word and presents it
//   with its decoded fields under a valid/ready handshake. Supports branch
//   redirects and stops on HALT_WORD until reset.
//   Ports:
//     Clk, Reset            clock (rising edge), async active-low reset
//     Start                 pulse; begins fetching from pc when idle
//     Enable, RW_ram        RAM enable, RAM read select (always read)
//     Address_in            RAM word address (follows pc)
//     mem_rdata             RAM read data
//     branch_valid/_target  redirect request and address
//     instr_ready           datapath accepts the held instruction
//     instr_valid           instruction and fields valid
//     instruction, instr_pc registered word and the address it came from
//     Cond..IV_Mov          fields sliced from the registered word
//     pc                    next fetch address
//     halted                halt reached
//   MEM_LATENCY must lie in 1..7.
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 32,
  parameter int                MEM_LATENCY = 1,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [DATA_W-1:0] HALT_WORD   = DATA_W'(cpu_isa_pkg::HALT_WORD)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic              Enable,
  output logic              RW_ram,
  output logic [ADDR_W-1:0] Address_in,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              instr_ready,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [3:0]        Cond,
  output logic [3:0]        OpCode,
  output logic              S,
  output logic [3:0]        destination,
  output logic [3:0]        source_2,
  output logic [3:0]        source_1,
  output logic [4:0]        IV_ShiftRor,
  output logic [15:0]       IV_Mov,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  import cpu_isa_pkg::*;

  localparam logic [FETCH_CNT_W-1:0] CNT_RELOAD = FETCH_CNT_W'(MEM_LATENCY - 1);

  fetch_state_t           state;
  logic [FETCH_CNT_W-1:0] wait_cnt;

  // The RAM is only ever read; the address is the registered pc, so it stays
  // stable for the whole FETCH window.
  assign RW_ram     = 1'b1;
  assign Address_in = pc;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      Enable      <= 1'b0;
      instr_valid <= 1'b0;
      instruction <= '0;
      instr_pc    <= '0;
      halted      <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (branch_valid) begin
            pc <= branch_target;
          end else if (Start) begin
            state    <= FETCH;
            Enable   <= 1'b1;
            wait_cnt <= CNT_RELOAD;
          end
        end

        FETCH: begin
          if (branch_valid) begin
            // Abandon the in-flight read; the new address gets a full window.
            pc       <= branch_target;
            wait_cnt <= CNT_RELOAD;
          end else if (wait_cnt == '0) begin
            instruction <= mem_rdata;
            instr_pc    <= pc;
            pc          <= pc + ADDR_W'(1);
            Enable      <= 1'b0;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end else begin
            wait_cnt <= wait_cnt - FETCH_CNT_W'(1);
          end
        end

        HOLD: begin
          if (branch_valid) begin
            // Whether or not it was accepted, the held word is retired and a
            // held HALT_WORD is not acted on.
            pc          <= branch_target;
            instr_valid <= 1'b0;
            Enable      <= 1'b1;
            wait_cnt    <= CNT_RELOAD;
            state       <= FETCH;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            if (instruction == HALT_WORD) begin
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              Enable   <= 1'b1;
              wait_cnt <= CNT_RELOAD;
              state    <= FETCH;
            end
          end
        end

        HALT: begin
          // Only reset leaves this state.
        end

        default: state <= IDLE;
      endcase
    end
  end

  instr_field_decoder #(
    .DATA_W (DATA_W)
  ) u_decoder (
    .instr        (instruction),
    .cond         (Cond),
    .op_code      (OpCode),
    .s_bit        (S),
    .destination  (destination),
    .source_2     (source_2),
    .source_1     (source_1),
    .iv_shift_ror (IV_ShiftRor),
    .iv_mov       (IV_Mov)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//   Two fetch units share one clock and one instruction RAM array:
//     u_dut  : MEM_LATENCY = 1, checked through a scoreboard of expected words
//     u_dut3 : MEM_LATENCY = 3, latency and asynchronous reset checks
//   Each RAM port returns garbage until Enable has been held on the same
//   address for the configured latency.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ram [0:65535];

  // ---------------- DUT with MEM_LATENCY = 1 ----------------
  logic        rst_n, start, branch_valid, instr_ready;
  logic [15:0] branch_target;
  logic        enable, rw_ram, instr_valid, s_bit, halted;
  logic [15:0] address_in, instr_pc, pc, iv_mov;
  logic [31:0] mem_rdata, instruction;
  logic [3:0]  cond, op_code, destination, source_2, source_1;
  logic [4:0]  iv_shift_ror;

  instruction_fetch_unit #(.MEM_LATENCY(1)) u_dut (
    .Clk(clk), .Reset(rst_n), .Start(start), .Enable(enable), .RW_ram(rw_ram),
    .Address_in(address_in), .mem_rdata(mem_rdata), .branch_valid(branch_valid),
    .branch_target(branch_target), .instr_ready(instr_ready), .instr_valid(instr_valid),
    .instruction(instruction), .instr_pc(instr_pc), .Cond(cond), .OpCode(op_code),
    .S(s_bit), .destination(destination), .source_2(source_2), .source_1(source_1),
    .IV_ShiftRor(iv_shift_ror), .IV_Mov(iv_mov), .pc(pc), .halted(halted)
  );

  // ---------------- DUT with MEM_LATENCY = 3 ----------------
  logic        rst_n3, start3, branch_valid3, instr_ready3;
  logic [15:0] branch_target3;
  logic        enable3, instr_valid3, halted3;
  logic [15:0] address_in3, instr_pc3, pc3;
  logic [31:0] mem_rdata3, instruction3;
  logic        unused_rw3, unused_s3;
  logic [3:0]  unused_cond3, unused_op3, unused_dst3, unused_s2_3, unused_s1_3;
  logic [4:0]  unused_sh3;
  logic [15:0] unused_mov3;

  instruction_fetch_unit #(.MEM_LATENCY(3)) u_dut3 (
    .Clk(clk), .Reset(rst_n3), .Start(start3), .Enable(enable3), .RW_ram(unused_rw3),
    .Address_in(address_in3), .mem_rdata(mem_rdata3), .branch_valid(branch_valid3),
    .branch_target(branch_target3), .instr_ready(instr_ready3), .instr_valid(instr_valid3),
    .instruction(instruction3), .instr_pc(instr_pc3), .Cond(unused_cond3),
    .OpCode(unused_op3), .S(unused_s3), .destination(unused_dst3), .source_2(unused_s2_3),
    .source_1(unused_s1_3), .IV_ShiftRor(unused_sh3), .IV_Mov(unused_mov3), .pc(pc3),
    .halted(halted3)
  );

  // ---------------- RAM latency models ----------------
  int          run1, held1, run3, held3;
  logic        prev_en1, prev_en3;
  logic [15:0] prev_addr1, prev_addr3;

  always_comb begin
    held1 = 0;
    if (enable) held1 = (prev_en1 && address_in == prev_addr1) ? run1 + 1 : 1;
  end
  always_comb begin
    held3 = 0;
    if (enable3) held3 = (prev_en3 && address_in3 == prev_addr3) ? run3 + 1 : 1;
  end
  always @(posedge clk) begin
    run1 <= held1; prev_en1 <= enable;  prev_addr1 <= address_in;
    run3 <= held3; prev_en3 <= enable3; prev_addr3 <= address_in3;
  end
  assign mem_rdata  = (held1 >= 1) ? ram[address_in]  : 32'hDEAD_BEEF;
  assign mem_rdata3 = (held3 >= 3) ? ram[address_in3] : 32'hDEAD_BEEF;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] word;
    logic [15:0] ipc;
    logic [15:0] next_pc;
    bit          chk_fields;
    logic [3:0]  cond, op, dst, s2, s1;
    logic        s;
    logic [4:0]  sh;
    logic [15:0] mov;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  logic prev_valid = 1'b0;
  logic prev_hs    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [31:0] word, input logic [15:0] ipc,
                           input logic [15:0] next_pc);
    exp_t x;
    x = '{default: '0};
    x.word = word; x.ipc = ipc; x.next_pc = next_pc;
    sb_q.push_back(x);
  endtask

  // A new presentation is the first valid cycle after an idle cycle or after a
  // completed handshake.
  always @(negedge clk) begin
    if (rst_n && instr_valid && (!prev_valid || prev_hs)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_instr", instruction, 32'h0);
      end else begin
        e = sb_q.pop_front();
        check("sb_instruction", instruction, e.word);
        check("sb_instr_pc", 32'(instr_pc), 32'(e.ipc));
        check("sb_pc", 32'(pc), 32'(e.next_pc));
        if (e.chk_fields) begin
          check("Cond", 32'(cond), 32'(e.cond));
          check("OpCode", 32'(op_code), 32'(e.op));
          check("S", 32'(s_bit), 32'(e.s));
          check("destination", 32'(destination), 32'(e.dst));
          check("source_2", 32'(source_2), 32'(e.s2));
          check("source_1", 32'(source_1), 32'(e.s1));
          check("IV_ShiftRor", 32'(iv_shift_ror), 32'(e.sh));
          check("IV_Mov", 32'(iv_mov), 32'(e.mov));
        end
      end
    end
    prev_valid <= instr_valid;
    prev_hs    <= instr_valid && instr_ready;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    start = 1'b0; branch_valid = 1'b0; instr_ready = 1'b0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    exp_t x;
    for (int i = 0; i < 65536; i++) ram[i] = 32'h0;
    rst_n = 1'b1; rst_n3 = 1'b1;
    start = 1'b0; branch_valid = 1'b0; instr_ready = 1'b0; branch_target = '0;
    start3 = 1'b0; branch_valid3 = 1'b0; instr_ready3 = 1'b0; branch_target3 = '0;
    #1;
    rst_n = 1'b0; rst_n3 = 1'b0;
    #1;
    // Reset state
    check("rst_Enable", 32'(enable), 32'h0);
    check("rst_RW_ram", 32'(rw_ram), 32'h1);
    check("rst_Address_in", 32'(address_in), 32'h0);
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'h0);
    check("rst_instruction", instruction, 32'h0);
    check("rst_instr_pc", 32'(instr_pc), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; rst_n3 = 1'b1;
    cyc();

    // ---- Streaming, latency 1 ----
    ram[0] = 32'h1111_1111; ram[1] = 32'h2222_2222;
    ram[2] = 32'h3333_3333; ram[3] = 32'h4444_4444; ram[4] = 32'h5555_5555;
    push_word(32'h1111_1111, 16'h0000, 16'h0001);
    push_word(32'h2222_2222, 16'h0001, 16'h0002);
    push_word(32'h3333_3333, 16'h0002, 16'h0003);
    instr_ready = 1'b1;
    start = 1'b1;
    cyc();                       // Start sampled at edge 0
    start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check($sformatf("stream_en_c%0d", i), 32'(enable), 32'(i % 2));
      check($sformatf("stream_valid_c%0d", i), 32'(instr_valid), 32'((i + 1) % 2));
      if (i % 2 == 1) check($sformatf("stream_addr_c%0d", i), 32'(address_in), 32'((i - 1) / 2));
      cyc();
    end

    // ---- Backpressure on word 3 ----
    instr_ready = 1'b0;          // cycle 7: word 3 being read
    push_word(32'h4444_4444, 16'h0003, 16'h0004);
    cyc();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(instr_valid), 32'h1);
      check("bp_instruction", instruction, 32'h4444_4444);
      check("bp_instr_pc", 32'(instr_pc), 32'h3);
      check("bp_enable", 32'(enable), 32'h0);
      check("bp_pc", 32'(pc), 32'h4);
      cyc();
    end
    instr_ready = 1'b1;
    push_word(32'h5555_5555, 16'h0004, 16'h0005);
    cyc();
    @(negedge clk);
    check("bp_next_en", 32'(enable), 32'h1);
    check("bp_next_addr", 32'(address_in), 32'h4);
    cyc();
    instr_ready = 1'b0;
    cyc();
    pulse_reset();

    // ---- Branch during FETCH ----
    ram[0] = 32'hAAAA_0000; ram[1] = 32'hBBBB_1111; ram[16'h10] = 32'hCCCC_2222;
    push_word(32'hAAAA_0000, 16'h0000, 16'h0001);
    push_word(32'hCCCC_2222, 16'h0010, 16'h0011);
    instr_ready = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();                       // cycle 2: word 0 presented and accepted
    cyc();                       // cycle 3: read of address 1 in flight
    branch_valid = 1'b1; branch_target = 16'h0010;
    @(negedge clk);
    check("br_inflight_en", 32'(enable), 32'h1);
    check("br_inflight_addr", 32'(address_in), 32'h1);
    cyc();
    branch_valid = 1'b0;
    instr_ready = 1'b0;
    @(negedge clk);
    check("br_restart_en", 32'(enable), 32'h1);
    check("br_restart_addr", 32'(address_in), 32'h10);
    cyc();
    cyc();
    pulse_reset();

    // ---- Halt ----
    ram[3] = 32'hFFFF_FFFF;
    branch_valid = 1'b1; branch_target = 16'h0003;
    cyc();
    branch_valid = 1'b0;
    @(negedge clk);
    check("idle_branch_pc", 32'(pc), 32'h3);
    check("idle_branch_en", 32'(enable), 32'h0);
    push_word(32'hFFFF_FFFF, 16'h0003, 16'h0004);
    cyc();
    instr_ready = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();                       // halt word presented and accepted
    cyc();
    for (int k = 0; k < 20; k++) begin
      start = (k % 4 == 1);
      branch_valid = (k % 4 == 3);
      branch_target = 16'h0020;
      @(negedge clk);
      check("halt_halted", 32'(halted), 32'h1);
      check("halt_enable", 32'(enable), 32'h0);
      check("halt_valid", 32'(instr_valid), 32'h0);
      cyc();
    end
    start = 1'b0; branch_valid = 1'b0;
    @(negedge clk);
    check("halt_pc", 32'(pc), 32'h4);
    cyc();
    pulse_reset();
    @(negedge clk);
    check("post_halt_rst_halted", 32'(halted), 32'h0);
    cyc();

    // ---- Decode and pc wrap ----
    ram[16'hFFFF] = 32'hE1A0_8800;
    branch_valid = 1'b1; branch_target = 16'hFFFF;
    cyc();
    branch_valid = 1'b0;
    x = '{default: '0};
    x.word = 32'hE1A0_8800; x.ipc = 16'hFFFF; x.next_pc = 16'h0000; x.chk_fields = 1'b1;
    x.cond = 4'hE; x.op = 4'h1; x.s = 1'b1; x.dst = 4'h4; x.s2 = 4'h1; x.s1 = 4'h1;
    x.sh = 5'h0; x.mov = 16'h1100;
    sb_q.push_back(x);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    @(negedge clk);
    check("wrap_hold_valid", 32'(instr_valid), 32'h1);
    check("wrap_pc", 32'(pc), 32'h0);
    cyc();
    pulse_reset();

    // ---- Latency 3 and asynchronous reset mid-FETCH ----
    ram[16'h42] = 32'h0BAD_F00D;
    branch_valid3 = 1'b1; branch_target3 = 16'h0042;
    cyc();
    branch_valid3 = 1'b0;
    start3 = 1'b1;
    cyc();
    start3 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("lat3_en_c%0d", i), 32'(enable3), 32'(i <= 3));
      check($sformatf("lat3_valid_c%0d", i), 32'(instr_valid3), 32'(i == 4));
      if (i == 4) begin
        check("lat3_instruction", instruction3, 32'h0BAD_F00D);
        check("lat3_instr_pc", 32'(instr_pc3), 32'h42);
      end
      if (i < 4) cyc();
    end
    instr_ready3 = 1'b1;
    cyc();                       // refetch of 0x43 begins
    instr_ready3 = 1'b0;
    @(negedge clk);
    check("lat3_refetch_en", 32'(enable3), 32'h1);
    check("lat3_refetch_pc", 32'(pc3), 32'h43);
    cyc();
    @(negedge clk);
    #2;
    rst_n3 = 1'b0;               // between edges, mid-FETCH
    #1;
    check("arst_enable", 32'(enable3), 32'h0);
    check("arst_valid", 32'(instr_valid3), 32'h0);
    check("arst_pc", 32'(pc3), 32'h0);
    check("arst_address", 32'(address_in3), 32'h0);
    check("arst_halted", 32'(halted3), 32'h0);
    cyc();
    rst_n3 = 1'b1;

    repeat (2) cyc();
    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
